// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// addr_bad() is only referenced when DMEM_ARB_ERR_EN is defined.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } arb_state_e;

    localparam int unsigned REQ_CPU    = 0;
    localparam int unsigned REQ_LDR    = 1;
    localparam int unsigned DMEM_WORDS = 1024;
    localparam int unsigned WORD_AW    = $clog2(DMEM_WORDS);

    // Callers zero-extend their address to 64 bits; misaligned or beyond 4 KB is bad.
    function automatic logic addr_bad(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a[63:12] != '0);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select: CPU priority, loader lock bursts and starvation relief.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CW           = 4
) (
    input  logic               [1:0] req,
    input  logic                     lock,
    input  logic                     last_win,
    input  logic [1:0][CW-1:0]       wait_cnt,
    output logic                     win
);

    always_comb begin
        win = 1'(REQ_CPU);
        if (req == 2'b10) begin
            win = 1'(REQ_LDR);
        end else if (req == 2'b01) begin
            win = 1'(REQ_CPU);
        end else if (lock && (last_win == 1'(REQ_LDR)) &&
                     (wait_cnt[REQ_CPU] < CW'(STARVE_LIMIT))) begin
            win = 1'(REQ_LDR);
        end else if (wait_cnt[REQ_LDR] >= CW'(STARVE_LIMIT)) begin
            win = 1'(REQ_LDR);
        end else begin
            win = 1'(REQ_CPU);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the 1024 x 32 data memory (CPU = 0, loader = 1).
// Define DMEM_ARB_ERR_EN to flag misaligned/out-of-range accesses on err_o.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned AW           = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_i,
    input  logic [1:0]           we_i,
    input  logic [1:0][AW-1:0]   addr_i,
    input  logic [1:0][31:0]     wdata_i,
    input  logic                 lock_i,
    output logic [1:0]           gnt_o,
    output logic [1:0]           rvalid_o,
    output logic [31:0]          rdata_o,
    output logic [1:0]           err_o,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    arb_state_e          state, state_nx;
    logic                win_q, pick_win, last_win;
    logic [1:0][CW-1:0]  wait_cnt;
    logic [31:0]         addr_q, wdata_q;
    logic                acc, cur_we, cur_bad;
    logic [AW-1:0]       cur_addr;
    logic [31:0]         access_addr;

    dmem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CW           (CW)
    ) u_pick (
        .req      (req_i),
        .lock     (lock_i),
        .last_win (last_win),
        .wait_cnt (wait_cnt),
        .win      (pick_win)
    );

    assign acc         = (state == ACCESS);
    assign cur_addr    = addr_i[win_q];
    assign cur_we      = we_i[win_q];
    assign access_addr = {{(32 - WORD_AW - 2){1'b0}}, cur_addr[WORD_AW+1:2], 2'b00};

`ifdef DMEM_ARB_ERR_EN
    assign cur_bad = addr_bad(64'(cur_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= '0;
        end else begin
            err_o <= '0;
            if (acc && cur_bad) err_o[win_q] <= 1'b1;
        end
    end
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cur_addr[AW-1:WORD_AW+2], cur_addr[1:0]};
    assign cur_bad          = 1'b0;
    assign err_o            = '0;
`endif

    always_comb begin
        state_nx  = state;
        gnt_o     = '0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        case (state)
            IDLE: begin
                if (|req_i) state_nx = ACCESS;
            end
            ACCESS: begin
                state_nx  = IDLE;
                gnt_o     = 2'b01 << win_q;
                mem_addr  = access_addr;
                mem_we    = cur_we && !cur_bad && !rst;
                if (cur_we) mem_wdata = wdata_i[win_q];
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            win_q    <= 1'(REQ_CPU);
            last_win <= 1'(REQ_CPU);
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_o  <= '0;
            rvalid_o <= '0;
        end else begin
            state    <= state_nx;
            rvalid_o <= '0;
            if (state == IDLE && |req_i) win_q <= pick_win;
            if (acc) begin
                last_win <= win_q;
                addr_q   <= access_addr;
                if (cur_we) wdata_q <= wdata_i[win_q];
                if (!cur_we && !cur_bad) begin
                    rvalid_o[win_q] <= 1'b1;
                    rdata_o         <= mem_rdata;
                end
            end
            // A dropped request or a grant both forfeit accumulated wait.
            for (int unsigned i = 0; i < 2; i++) begin
                if (!req_i[i] || gnt_o[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] < CW'(STARVE_LIMIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024 x 32 memory.
module tb_dmem_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req, we;
    logic [1:0][31:0]  addr, wdata;
    logic              lock;
    logic [1:0]        gnt, rvalid, err;
    logic [31:0]       rdata;
    logic              mem_we;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic              mem_init;
    logic [31:0]       tb_mem [0:1023];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .STARVE_LIMIT (8),
        .AW           (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .lock_i    (lock),
        .gnt_o     (gnt),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .err_o     (err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_we) begin
            tb_mem[mem_addr[11:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = tb_mem[mem_addr[11:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_init = 1'b1; lock = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        rst = 1'b0; mem_init = 1'b0;

        // Single CPU write then read of 0x10
        req = 2'b01; we = 2'b01; addr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF;
        chk("idle_gnt", 32'(gnt), 32'h0);
        tick();
        chk("cpu_wr_gnt", 32'(gnt), 32'h1);
        chk("cpu_wr_we", 32'(mem_we), 32'h1);
        chk("cpu_wr_addr", mem_addr, 32'h10);
        chk("cpu_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("cpu_wr_norv", 32'(rvalid), 32'h0);
        chk("cpu_wr_idle_we", 32'(mem_we), 32'h0);
        chk("cpu_wr_hold_addr", mem_addr, 32'h10);
        we = 2'b00;
        tick();
        chk("cpu_rd_gnt", 32'(gnt), 32'h1);
        chk("cpu_rd_we", 32'(mem_we), 32'h0);
        tick();
        chk("cpu_rd_rvalid", 32'(rvalid), 32'h1);
        chk("cpu_rd_rdata", rdata, 32'hDEAD_BEEF);
        chk("cpu_rd_err", 32'(err), 32'h0);
        req = 2'b00;
        tick();
        chk("cpu_rd_rv_pulse", 32'(rvalid), 32'h0);

        // Simultaneous reads, no lock: CPU first, loader two cycles later
        req = 2'b11; we = 2'b00; addr[0] = 32'h0; addr[1] = 32'h4;
        tick();
        chk("sim_gnt_cpu", 32'(gnt), 32'h1);
        chk("sim_addr_cpu", mem_addr, 32'h0);
        tick();
        chk("sim_rv_cpu", 32'(rvalid), 32'h1);
        chk("sim_rd_cpu", rdata, 32'h1000_0000);
        req = 2'b10;
        tick();
        chk("sim_gnt_ldr", 32'(gnt), 32'h2);
        chk("sim_addr_ldr", mem_addr, 32'h4);
        tick();
        chk("sim_rv_ldr", 32'(rvalid), 32'h2);
        chk("sim_rd_ldr", rdata, 32'h1000_0001);
        req = 2'b00;
        tick();

        // Starvation: CPU continuous, loader pending
        req = 2'b11; we = 2'b00; addr[0] = 32'hC; addr[1] = 32'h8;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("starve_gnt_cpu", 32'(gnt), 32'h1);
            tick();
            chk("starve_rv_cpu", 32'(rvalid), 32'h1);
            chk("starve_rd_cpu", rdata, 32'h1000_0003);
        end
        chk("starve_wait1_sat", 32'(dut.wait_cnt[1]), 32'd8);
        tick();
        chk("starve_gnt_ldr", 32'(gnt), 32'h2);
        chk("starve_addr_ldr", mem_addr, 32'h8);
        tick();
        chk("starve_rv_ldr", 32'(rvalid), 32'h2);
        chk("starve_rd_ldr", rdata, 32'h1000_0002);
        chk("starve_wait1_clr", 32'(dut.wait_cnt[1]), 32'd0);
        req = 2'b00;
        tick();

        // Locked burst: loader was last winner, writes 0x100..0x10C while CPU waits
        lock = 1'b1; req = 2'b11; we = 2'b10;
        addr[0] = 32'h10; addr[1] = 32'h100; wdata[1] = 32'hA000_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("burst_gnt", 32'(gnt), 32'h2);
            chk("burst_we", 32'(mem_we), 32'h1);
            chk("burst_addr", mem_addr, 32'h100 + 32'(4 * i));
            tick();
            if (i < 3) begin
                addr[1]  = 32'h100 + 32'(4 * (i + 1));
                wdata[1] = 32'hA000_0000 + 32'(i + 1);
            end else begin
                addr[1] = 32'h100;
                we      = 2'b00;
            end
        end
        chk("burst_wait0_sat", 32'(dut.wait_cnt[0]), 32'd8);
        tick();
        chk("burst_gnt_cpu", 32'(gnt), 32'h1);
        tick();
        chk("burst_rv_cpu", 32'(rvalid), 32'h1);
        chk("burst_rd_cpu", rdata, 32'hDEAD_BEEF);
        req = 2'b10;
        tick();
        chk("burst_gnt_ldr_rd", 32'(gnt), 32'h2);
        tick();
        chk("burst_rv_ldr", 32'(rvalid), 32'h2);
        chk("burst_rd_ldr", rdata, 32'hA000_0000);
        chk("burst_mem1", tb_mem[32'h41], 32'hA000_0001);
        chk("burst_mem3", tb_mem[32'h43], 32'hA000_0003);
        req = 2'b00; lock = 1'b0;
        tick();

        // Reset in the ACCESS cycle of a write
        req = 2'b01; we = 2'b01; addr[0] = 32'h20; wdata[0] = 32'h5A5A_5A5A;
        tick();
        chk("rstw_gnt", 32'(gnt), 32'h1);
        chk("rstw_we_pre", 32'(mem_we), 32'h1);
        rst = 1'b1;
        #1;
        chk("rstw_we_forced", 32'(mem_we), 32'h0);
        tick();
        rst = 1'b0; req = 2'b00;
        chk("rstw_idle_gnt", 32'(gnt), 32'h0);
        chk("rstw_norv", 32'(rvalid), 32'h0);
        tick();
        chk("rstw_norv2", 32'(rvalid), 32'h0);
        chk("rstw_mem", tb_mem[8], 32'h1000_0008);
        chk("rstw_rdata", rdata, 32'h0);

`ifdef DMEM_ARB_ERR_EN
        // Misaligned write and out-of-range read
        req = 2'b01; we = 2'b01; addr[0] = 32'h2; wdata[0] = 32'h1111_1111;
        tick();
        chk("err_wr_gnt", 32'(gnt), 32'h1);
        chk("err_wr_we", 32'(mem_we), 32'h0);
        tick();
        chk("err_wr_err", 32'(err), 32'h1);
        chk("err_wr_norv", 32'(rvalid), 32'h0);
        we = 2'b00; addr[0] = 32'h1000;
        tick();
        chk("err_rd_gnt", 32'(gnt), 32'h1);
        chk("err_rd_we", 32'(mem_we), 32'h0);
        tick();
        chk("err_rd_err", 32'(err), 32'h1);
        chk("err_rd_norv", 32'(rvalid), 32'h0);
        chk("err_rd_rdata", rdata, 32'h0);
        chk("err_mem0", tb_mem[0], 32'h1000_0000);
        req = 2'b00;
        tick();
        chk("err_pulse", 32'(err), 32'h0);
`else
        // Without error checking, upper and low address bits are ignored
        req = 2'b01; we = 2'b00; addr[0] = 32'h0000_1013;
        tick();
        chk("noerr_addr", mem_addr, 32'h10);
        tick();
        chk("noerr_rv", 32'(rvalid), 32'h1);
        chk("noerr_rdata", rdata, 32'hDEAD_BEEF);
        chk("noerr_err", 32'(err), 32'h0);
        req = 2'b00;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer in front of the single-port 4 KB data memory (1024 x 32-bit words, asynchronous read, synchronous write). It shares the memory between the CPU load/store unit (requester 0) and an external loader/debug port (requester 1). Priority is fixed to the CPU, with a starvation counter that guarantees the other requester progress and a lock that lets the loader run uninterrupted bursts. It drives the memory's `we`, `addr` and `wdata` and registers its `rdata` back to the owning requester.

## Interface
- `STARVE_LIMIT`, default 8: number of cycles a losing requester may wait before it wins the next grant.
- `AW`, default 32: requester address width.
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-high.
- `req_i[1:0]` in, 2: request per requester, index 0 = CPU, 1 = loader.
- `we_i[1:0]` in, 2: 1 = write, 0 = read, per requester.
- `addr_i[1:0]` in, 2 x AW: byte address per requester.
- `wdata_i[1:0]` in, 2 x 32: write data per requester.
- `lock_i` in, 1: loader burst lock.
- `gnt_o[1:0]` out, 2: one-hot grant pulse.
- `rvalid_o[1:0]` out, 2: read-data-valid pulse.
- `rdata_o` out, 32: registered read data, shared by both requesters.
- `err_o[1:0]` out, 2: error pulse (only when DMEM_ARB_ERR_EN is defined, otherwise tied to 0).
- `mem_we` out, 1: memory write enable.
- `mem_addr` out, 32: memory address.
- `mem_wdata` out, 32: memory write data.
- `mem_rdata` in, 32: memory read data.

## Operation
- Requester rules:
  - A requester holds `req`, `we`, `addr` and `wdata` stable from assertion until it samples its `gnt`.
  - It may re-assert `req` in the cycle after `gnt`.
- The FSM has two states, IDLE and ACCESS.
- **IDLE:** if any `req` is high, pick a winner, capture its index, and go to ACCESS.
- **ACCESS:** drive `gnt_o[win]` and `mem_addr = addr_i[win]`.
  - For a write, assert `mem_we` and drive `mem_wdata = wdata_i[win]`.
  - For a read, capture `mem_rdata` into `rdata_o` at the end of the cycle.
  - Always return to IDLE.
- Winner selection is applied in this order:
  1. If only one requester is requesting, it wins.
  2. If `lock_i` is high, the loader was the last winner, and the CPU's `wait_cnt[0]` < STARVE_LIMIT, the loader wins.
  3. Otherwise, if `wait_cnt[1]` ≥ STARVE_LIMIT, the loader wins.
  4. Otherwise the CPU wins.
- Wait counters:
  - `wait_cnt[i]` increments, saturating at STARVE_LIMIT, on every cycle in which `req_i[i]` is high and `gnt_o[i]` is low.
  - It clears when `gnt_o[i]` is asserted.
  - It also clears in any cycle in which `req_i[i]` is low.
- `last_win` updates on every grant and resets to 0 (CPU).
- `rvalid_o[win]` pulses for reads only. Writes complete on `gnt`.
- `mem_we` is forced to 0 while `rst` is high.

## Timing
- Reset values: state IDLE; `gnt_o`, `rvalid_o` and `err_o` all 0; `rdata_o` 0; `mem_we` 0; `wait_cnt` 0; `last_win` 0.
- Cycle sequence for a request raised in IDLE:
  - Cycle N: `req` seen in IDLE.
  - Cycle N+1: `gnt` asserted; a write commits at the N+1 clock edge.
  - Cycle N+2: `rvalid` and `rdata_o` valid.
- Throughput is one access per 2 cycles.
- `mem_addr` and `mem_wdata` hold their last driven values when idle. `mem_we` is 0 except in a write ACCESS cycle.
- Simultaneous requests resolve in a single cycle using the priority order in Operation.
- If `rst` is asserted during ACCESS:
  - The write is suppressed.
  - The FSM is in IDLE on the next cycle.
  - No `rvalid` is issued for the aborted access.
- If a requester drops `req` before being granted, no access is made for it.

## Configuration
- `DMEM_ARB_ERR_EN` defined:
  - An access with `addr[1:0] != 0` or `addr[AW-1:12] != 0` is an error.
  - It is still granted, but `mem_we` stays 0.
  - `err_o[win]` pulses at N+2 (the `rvalid` slot) for both reads and writes; `rvalid_o` stays 0 and `rdata_o` is unchanged.
- `DMEM_ARB_ERR_EN` undefined:
  - Word index is `addr[11:2]`; upper bits and `addr[1:0]` are ignored.
  - `err_o` is tied to 0.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum `arb_state_e` (IDLE, ACCESS);
  - requester index constants `REQ_CPU = 0` and `REQ_LDR = 1`;
  - `DMEM_WORDS = 1024`;
  - the address-check function used under DMEM_ARB_ERR_EN.
- One sub-module, `dmem_arb_pick`: a combinational winner select taking `req`, `lock`, `last_win` and `wait_cnt`.
- The FSM, counters and response registers live in `dmem_arbiter`.

## Test plan
- **Single CPU access:** CPU write of 0xDEADBEEF to address 0x10, then a read of 0x10 → `gnt_o = 01` at N+1 for each access; on the read, `rvalid_o[0]` at N+2 with `rdata_o = 0xDEADBEEF`.
- **Simultaneous reads:** both requesters read (CPU 0x0, loader 0x4) with no lock → CPU granted first, loader granted 2 cycles later; each `rvalid` lands on the correct index.
- **Starvation:** CPU requests continuously while the loader is held pending → loader granted once `wait_cnt[1]` reaches 8, then `wait_cnt[1] = 0`.
- **Locked burst:** with `lock_i = 1`, the loader writes 4 words at 0x100–0x10C while the CPU requests → loader keeps winning until `wait_cnt[0] = 8`, then the CPU is granted once.
- **Reset during write:** assert `rst` in the ACCESS cycle of a write of 0x5A5A5A5A to 0x20 → `mem_we = 0`, FSM in IDLE on the next cycle, no `rvalid`.
- **Error path (DMEM_ARB_ERR_EN defined):** write to 0x2 and read from 0x1000 → `mem_we` never asserts; `err_o` pulses at N+2 for each access; `rvalid_o` stays 0.
